// File: rtl/layer_pipeline_sequencer.sv
// Layer sequencer: waits for the end of an input-image load, then enables each layer engine in turn,
// with a settle stall after every layer, a per-layer watchdog, abort on en drop and a done pulse.
module layer_pipeline_sequencer #(
   parameter int NUM_LAYERS     = 5,
   parameter int STALL_CYCLES   = 1000,
   parameter int TIMEOUT_CYCLES = 0,
   parameter int CNT_W          = 32,
   parameter int IDX_W          = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  we,
   input  logic [NUM_LAYERS-1:0] layer_fin,
   output logic [NUM_LAYERS-1:0] layer_en,
   output logic [IDX_W-1:0]      cur_layer,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_STALL,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [CNT_W-1:0] STALL_LAST   = CNT_W'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_LAYERS - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             we_d;
   logic             load_end;
   logic             cur_fin;
   logic             last_layer;
   logic [IDX_W-1:0] next_layer;

   // Counter never wraps, so a very long layer cannot alias back to a small count.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [NUM_LAYERS-1:0] one_hot(input logic [IDX_W-1:0] idx);
      return NUM_LAYERS'(1) << idx;
   endfunction

   assign load_end   = we_d & ~we;
   assign cur_fin    = layer_fin[cur_layer];
   assign last_layer = (cur_layer == LAST_IDX);
   assign next_layer = cur_layer + IDX_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         layer_en    <= '0;
         cur_layer   <= '0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         we_d        <= 1'b0;
      end else begin
         we_d <= we;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (en) state <= S_LOAD;
            end
            S_LOAD: begin
               if (!en) begin
                  state <= S_IDLE;
               end else if (load_end) begin
                  state     <= S_RUN;
                  cur_layer <= '0;
                  layer_en  <= one_hot('0);
                  cnt       <= '0;
                  busy      <= 1'b1;
               end
            end
            S_RUN: begin
               if (!en) begin
                  state     <= S_IDLE;
                  layer_en  <= '0;
                  cnt       <= '0;
                  cur_layer <= '0;
                  busy      <= 1'b0;
               end else if (cur_fin) begin
                  layer_en <= '0;
                  cnt      <= '0;
                  if (STALL_CYCLES != 0) begin
                     state <= S_STALL;
                  end else if (!last_layer) begin
                     cur_layer <= next_layer;
                     layer_en  <= one_hot(next_layer);
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end else if ((TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_LAST)) begin
                  state       <= S_ERR;
                  layer_en    <= '0;
                  timeout_err <= 1'b1;
                  busy        <= 1'b0;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            S_STALL: begin
               if (!en) begin
                  state     <= S_IDLE;
                  cnt       <= '0;
                  cur_layer <= '0;
                  busy      <= 1'b0;
               end else if (cnt == STALL_LAST) begin
                  cnt <= '0;
                  if (!last_layer) begin
                     state     <= S_RUN;
                     cur_layer <= next_layer;
                     layer_en  <= one_hot(next_layer);
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               cur_layer <= '0;
            end
            S_ERR: begin
               // Flag stays up until the host withdraws permission.
               if (!en) begin
                  state       <= S_IDLE;
                  timeout_err <= 1'b0;
                  cur_layer   <= '0;
               end
            end
            default: begin
               state    <= S_IDLE;
               layer_en <= '0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_pipeline_sequencer.sv
// Bench for layer_pipeline_sequencer: expected output traces are built from per-layer run lengths,
// stall length and watchdog limit, and compared cycle by cycle while reactive layer engines drive fin.
module tb_layer_pipeline_sequencer;

   localparam int NL  = 3;
   localparam int S_A = 4;
   localparam int T_A = 50;
   localparam int IW  = 2;
   localparam int CW  = 16;

   typedef logic [7:0] vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          en_a, en_b, we;
   logic [NL-1:0] fin;
   logic [NL-1:0] len_a, len_b;
   logic [IW-1:0] cur_a, cur_b;
   logic          busy_a, busy_b, done_a, done_b, terr_a, terr_b;

   int checks = 0;
   int errors = 0;
   int dly[NL];

   layer_pipeline_sequencer #(
      .NUM_LAYERS(NL), .STALL_CYCLES(S_A), .TIMEOUT_CYCLES(T_A), .CNT_W(CW), .IDX_W(IW)
   ) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .we(we), .layer_fin(fin),
      .layer_en(len_a), .cur_layer(cur_a), .busy(busy_a), .done(done_a), .timeout_err(terr_a)
   );

   layer_pipeline_sequencer #(
      .NUM_LAYERS(NL), .STALL_CYCLES(0), .TIMEOUT_CYCLES(0), .CNT_W(CW), .IDX_W(IW)
   ) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .we(we), .layer_fin(fin),
      .layer_en(len_b), .cur_layer(cur_b), .busy(busy_b), .done(done_b), .timeout_err(terr_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input vec_t obs, input vec_t exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed={en,busy,done,cur,terr}=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic vec_t mk(input int idx, input bit b, input bit d, input int c, input bit t);
      logic [NL-1:0] le;
      le = (idx < 0) ? '0 : NL'(1 << idx);
      return {le, b, d, IW'(c), t};
   endfunction

   function automatic vec_t get_obs(input int sel);
      if (sel == 0) return {len_a, busy_a, done_a, cur_a, terr_a};
      return {len_b, busy_b, done_b, cur_b, terr_b};
   endfunction

   task automatic set_en(input int sel, input logic v);
      if (sel == 0) en_a = v;
      else en_b = v;
   endtask

   // One full sequence: setup (ignored IDLE load, LOAD), then trace comparison with reactive engines.
   task automatic run_seq(input string name, input int sel, input int load_len, input int hang,
                          input int abort_at, input int rst_at, input bit hold_fin, input bit strays);
      vec_t trace[$];
      int   s;
      int   drop_at;
      int   ecnt[NL];
      vec_t obs;
      s       = (sel == 0) ? S_A : 0;
      drop_at = -1;
      for (int i = 0; i < NL; i++) ecnt[i] = 0;

      for (int i = 0; i < NL; i++) begin
         if (i == hang) begin
            repeat (T_A) trace.push_back(mk(i, 1, 0, i, 0));
            repeat (5) trace.push_back(mk(-1, 0, 0, i, 1));
            drop_at = trace.size() - 1;
            break;
         end
         repeat (dly[i]) trace.push_back(mk(i, 1, 0, i, 0));
         repeat (s) trace.push_back(mk(-1, 1, 0, i, 0));
      end
      if (hang < 0) trace.push_back(mk(-1, 0, 1, NL - 1, 0));
      if (abort_at >= 0) begin
         while (trace.size() > abort_at + 1) void'(trace.pop_back());
         drop_at = abort_at;
      end
      trace.push_back(mk(-1, 0, 0, 0, 0));

      fin = '0;
      @(negedge clk); we = 1'b1;
      @(negedge clk); we = 1'b0;
      @(negedge clk);
      check({name, "_idle"}, get_obs(sel), mk(-1, 0, 0, 0, 0));
      set_en(sel, 1'b1);
      @(negedge clk);
      check({name, "_load"}, get_obs(sel), mk(-1, 0, 0, 0, 0));
      if (hold_fin) fin = '1;
      we = 1'b1;
      repeat (load_len) @(negedge clk);
      we = 1'b0;

      for (int k = 0; k < trace.size(); k++) begin
         @(negedge clk);
         obs = get_obs(sel);
         check(name, obs, trace[k]);
         if (k == rst_at) begin
            #2 rst = 1'b1;
            #1 check({name, "_rst_async"}, get_obs(sel), 8'h00);
            @(negedge clk);
            rst = 1'b0;
            set_en(sel, 1'b0);
            fin = '0;
            return;
         end
         for (int i = 0; i < NL; i++) begin
            if (hold_fin) fin[i] = 1'b1;
            else if (obs[8-NL+i]) begin
               ecnt[i]++;
               fin[i] = (i != hang) && (ecnt[i] >= dly[i]);
            end else fin[i] = strays && ($urandom_range(0, 3) == 0);
         end
         if (k == drop_at) set_en(sel, 1'b0);
      end
      set_en(sel, 1'b0);
      fin = '0;
   endtask

   initial begin
      int sel, mode, hang, abort_at, sum;
      rst = 1'b0; en_a = 1'b0; en_b = 1'b0; we = 1'b0; fin = '0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_a", get_obs(0), 8'h00);
      check("reset_b", get_obs(1), 8'h00);
      rst = 1'b0;

      dly = '{20, 20, 20};
      run_seq("full_seq", 0, 10, -1, -1, -1, 1'b0, 1'b1);
      dly = '{1, 1, 1};
      run_seq("no_stall_hold_fin", 1, 3, -1, -1, -1, 1'b1, 1'b0);
      dly = '{7, 1, 1};
      run_seq("watchdog", 0, 4, 1, -1, -1, 1'b0, 1'b0);
      dly = '{9, 6, 6};
      run_seq("abort_stall", 0, 2, -1, 9 + 2, -1, 1'b0, 1'b0);
      dly = '{12, 15, 5};
      run_seq("rst_mid", 0, 5, -1, -1, 12 + S_A + 3, 1'b0, 1'b1);

      for (int it = 0; it < 10; it++) begin
         sel = $urandom_range(0, 1);
         sum = 0;
         for (int i = 0; i < NL; i++) begin
            dly[i] = $urandom_range(1, 25);
            sum += dly[i];
         end
         mode     = $urandom_range(0, 2);
         hang     = -1;
         abort_at = -1;
         if (mode == 1) abort_at = $urandom_range(0, sum + NL * ((sel == 0) ? S_A : 0) - 1);
         if (mode == 2 && sel == 0) hang = $urandom_range(0, NL - 1);
         run_seq("random", sel, $urandom_range(1, 8), hang, abort_at, -1, 1'b0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL sim_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
